kamus_lsu: RTL and testbench
============================

// Module: kamus_lsu
// PURPOSE
//  Load/store unit; consumes the memory-side decisions of the control unit (l1d_wr_en, MEM_RESULT
//  writeback select). Accepts one load/store per handshake from execute and drives a req/gnt/rvalid
//  L1D port with byte strobes. Returns the aligned, sign/zero-extended load data (or store completion)
//  to writeback. Single outstanding transaction; sits between execute and the L1D.
// PARAMETERS
//  XLEN          32   data/address width (only 32 supported)
//  WAIT_TIMEOUT  255  max cycles in REQ or WAIT before abort with error; 0 = timeout disabled
// PORTS
//  clk_i           in   1     core clock
//  rst_ni          in   1     synchronous active-low reset
//  req_valid_i     in   1     execute presents a memory op
//  req_ready_o     out  1     LSU can accept (state IDLE)
//  req_we_i        in   1     1 = store (CU l1d_wr_en), 0 = load
//  req_size_i      in   2     00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned_i  in   1     1 = LBU/LHU zero-extend
//  req_addr_i      in   XLEN  byte address (ALU result)
//  req_wdata_i     in   XLEN  store data (rs2)
//  req_rd_i        in   5     destination register tag, echoed on response
//  mem_req_o       out  1     L1D request
//  mem_gnt_i       in   1     L1D accepts request this cycle
//  mem_we_o        out  1     L1D write
//  mem_be_o        out  4     byte enables
//  mem_addr_o      out  XLEN  word-aligned address ({addr[31:2],2'b00})
//  mem_wdata_o     out  XLEN  lane-aligned store data
//  mem_rvalid_i    in   1     load data valid
//  mem_rdata_i     in   XLEN  load data word
//  rsp_valid_o     out  1     one-cycle completion pulse to writeback
//  rsp_rdata_o     out  XLEN  extended load data (0 for stores/errors)
//  rsp_rd_o        out  5     captured req_rd_i
//  rsp_err_o       out  1     access error (timeout, or misaligned when enabled)
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): state IDLE, timeout counter 0, all registered outputs 0;
//   req_ready_o=1 after reset. Reset mid-transaction aborts it; no rsp_valid_o is produced.
//  FSM IDLE -> REQ -> (WAIT) -> RESP -> IDLE:
//   IDLE: req_ready_o=1; req_valid_i&req_ready_o captures addr/size/we/unsigned/wdata/rd -> REQ.
//   REQ: mem_req_o=1; mem_* stable until mem_gnt_i. gnt&store -> RESP; gnt&load -> WAIT.
//   WAIT: mem_req_o=0; mem_rvalid_i captures extended data -> RESP. rvalid is never sampled in
//    the grant cycle (L1D latency >= 1); rvalid in IDLE/REQ/RESP is ignored.
//   RESP: rsp_valid_o=1 exactly one cycle; req_ready_o=0 -> IDLE. Back-to-back accept next cycle.
//  Latency from accept edge (zero-wait L1D): store rsp 2 cycles later, load rsp 3 cycles later.
//  Byte lanes: SB be=4'b0001<<a[1:0], wdata = byte replicated x4; SH be=4'b0011<<{a[1],1'b0},
//   wdata = half replicated x2; SW/reserved be=4'b1111.
//  Load extract: byte lane a[1:0] / half lane a[1]; sign-extend unless req_unsigned_i.
//  Timeout: counter clears on entering REQ, increments each cycle in REQ/WAIT; on reaching
//   WAIT_TIMEOUT -> RESP with rsp_err_o=1, rdata=0, mem_req_o dropped. gnt/rvalid in the same
//   cycle as expiry win (normal completion).
//  rsp_err_o/rsp_rdata_o/rsp_rd_o valid only while rsp_valid_o=1; otherwise 0.
// CONFIGURATION
//  KAMUS_LSU_MISALIGN_EXC_EN defined: half with a[0]=1, word with a[1:0]!=0, or size 11 ->
//   no L1D access; IDLE -> RESP directly, rsp_err_o=1, rdata=0 (rsp 1 cycle after accept).
//  Not defined: low address bits that violate alignment are ignored (half uses a[1], word forces
//   lane 0); size 11 treated as word; rsp_err_o only from timeout.
// TESTING
//  SB addr=0x1003 wdata=0xAB, gnt immediate -> mem_be_o=1000, mem_wdata_o=0xABABABAB,
//   mem_addr_o=0x1000, rsp_valid_o 2 cycles after accept.
//  LB addr=0x2001, rdata=0x0000_8000 -> rsp_rdata_o=0xFFFF_FF80; LBU -> 0x0000_0080.
//  LH addr=0x2002, rdata=0x8001_0000, gnt held off 3 cycles -> mem_* stable, rdata=0xFFFF_8001.
//  Load, no rvalid, WAIT_TIMEOUT=8 -> rsp_valid_o with rsp_err_o=1, rdata=0, then req_ready_o=1.
//  LW addr=0x3002: macro on -> no mem_req_o, rsp_err_o=1 next cycle; macro off -> addr 0x3000 read.
//  rst_ni low during WAIT, rvalid arrives after reset -> no rsp_valid_o, state IDLE, ready=1.

Source files
------------

// File: rtl/kamus_lsu.sv
// kamus_lsu -- load/store unit between execute and the L1D.
//
// Accepts one load or store per req_valid_i/req_ready_o handshake, issues it
// on a req/gnt/rvalid L1D port with byte enables, and returns the aligned,
// sign/zero-extended load data (or a store completion) as a one-cycle
// rsp_valid_o pulse. Only one transaction is ever outstanding.
//
// Parameters:
//   XLEN          data/address width (only 32 supported)
//   WAIT_TIMEOUT  cycles allowed in REQ+WAIT before aborting with an error;
//                 0 disables the timeout
//
// Optional feature macro: KAMUS_LSU_MISALIGN_EXC_EN
//   Defined     : misaligned half/word and reserved size complete at once
//                 with rsp_err_o=1 and never touch the L1D.
//   Not defined : offending low address bits are ignored, size 11 acts as
//                 a word access.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   req_valid_i / req_ready_o     request handshake from execute
//   req_we_i, req_size_i,         store flag, access size, zero-extend flag
//   req_unsigned_i
//   req_addr_i, req_wdata_i,      byte address, store data, dest reg tag
//   req_rd_i
//   mem_req_o / mem_gnt_i         L1D request handshake
//   mem_we_o, mem_be_o,           L1D write flag, byte enables,
//   mem_addr_o, mem_wdata_o       word-aligned address, lane-aligned data
//   mem_rvalid_i, mem_rdata_i     L1D load return
//   rsp_valid_o, rsp_rdata_o,     completion pulse, extended load data,
//   rsp_rd_o, rsp_err_o           echoed tag, access error

module kamus_lsu #(
    parameter int XLEN         = 32,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [4:0]      req_rd_i,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic [4:0]      rsp_rd_o,
    output logic            rsp_err_o
);

    localparam int CNT_W     = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam int TO_LAST_I = (WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]  addr_q;
    logic [1:0]       size_q;
    logic             we_q;
    logic             uns_q;
    logic [XLEN-1:0]  wdata_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;
    logic             misal_in;

    // Store byte enables for the addressed lane(s).
    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate sub-word store data so every lane carries it.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] sz, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (sz)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/half out of the returned word and extend it.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] w,
                                                    input logic [1:0] sz,
                                                    input logic [1:0] a,
                                                    input logic uns);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{(XLEN-8){~uns & b[7]}}, b};
            2'b01:   r = {{(XLEN-16){~uns & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef KAMUS_LSU_MISALIGN_EXC_EN
    always_comb begin
        misal_in = 1'b0;
        case (req_size_i)
            2'b01:   misal_in = req_addr_i[0];
            2'b10:   misal_in = (req_addr_i[1:0] != 2'b00);
            2'b11:   misal_in = 1'b1;
            default: misal_in = 1'b0;
        endcase
    end
`else
    assign misal_in = 1'b0;
`endif

    // Expiry fires on the cycle that would bring the count to WAIT_TIMEOUT.
    assign timeout_hit = (WAIT_TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant or rvalid arriving in the expiry cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) state_d = misal_in ? S_RESP : S_REQ;
            end
            S_REQ: begin
                if (mem_gnt_i)        state_d = we_q ? S_RESP : S_WAIT;
                else if (timeout_hit) state_d = S_RESP;
            end
            S_WAIT: begin
                if (mem_rvalid_i || timeout_hit) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        size_q  <= req_size_i;
                        we_q    <= req_we_i;
                        uns_q   <= req_unsigned_i;
                        wdata_q <= req_wdata_i;
                        rd_q    <= req_rd_i;
                        rdata_q <= '0;
                        err_q   <= misal_in;
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (!mem_gnt_i && timeout_hit) err_q <= 1'b1;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid_i)
                        rdata_q <= load_extend(mem_rdata_i, size_q, addr_q[1:0], uns_q);
                    else if (timeout_hit)
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_be_o    = mem_req_o ? lane_be(size_q, addr_q[1:0]) : 4'b0000;
    assign mem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata_o = lane_wdata(size_q, wdata_q);

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_rd_o    = rsp_valid_o ? rd_q : 5'd0;
    assign rsp_err_o   = rsp_valid_o & err_q;

endmodule

// File: tb/tb_kamus_lsu.sv
module tb_kamus_lsu;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    kamus_lsu #(.XLEN(32), .WAIT_TIMEOUT(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_rd_i       (req_rd),
        .mem_req_o      (mem_req),
        .mem_gnt_i      (mem_gnt),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_rd_o       (rsp_rd),
        .rsp_err_o      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
        req_rd       = rd;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        tick;
        tick;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (mem_be !== 4'b0000) begin fails++; $display("FAIL reset_be: got %b want 0000", mem_be); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        rst_ni = 1'b1;
        tick;
    endtask

    task automatic test_store_byte;
        drive_req(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd3);
        mem_gnt = 1'b1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL sb_ready: got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL sb_mem_req: got %b want 1", mem_req); end
        tests++; if (mem_be !== 4'b1000) begin fails++; $display("FAIL sb_be: got %b want 1000", mem_be); end
        tests++; if (mem_wdata !== 32'hABAB_ABAB) begin fails++; $display("FAIL sb_wdata: got %h want ababab ab", mem_wdata); end
        tests++; if (mem_addr !== 32'h0000_1000) begin fails++; $display("FAIL sb_addr: got %h want 00001000", mem_addr); end
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL sb_we: got %b want 1", mem_we); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL sb_early_rsp: got %b want 0", rsp_valid); end
        tick;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL sb_rsp_valid: got %b want 1", rsp_valid); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL sb_err: got %b want 0", rsp_err); end
        tests++; if (rsp_rd !== 5'd3) begin fails++; $display("FAIL sb_rd: got %0d want 3", rsp_rd); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL sb_rdata: got %h want 0", rsp_rdata); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL sb_ready_resp: got %b want 0", req_ready); end
        tick;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL sb_pulse: got %b want 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL sb_ready_idle: got %b want 1", req_ready); end
    endtask

    task automatic test_load_byte;
        logic [31:0] exp_data [2];
        exp_data[0] = 32'hFFFF_FF80;
        exp_data[1] = 32'h0000_0080;
        for (int u = 0; u < 2; u++) begin
            drive_req(1'b0, 2'b00, u[0], 32'h0000_2001, 32'h0, 5'd7);
            mem_gnt = 1'b1;
            tick;
            req_valid = 1'b0;
            tests++; if (mem_be !== 4'b0010) begin fails++; $display("FAIL lb_be[%0d]: got %b want 0010", u, mem_be); end
            tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL lb_we[%0d]: got %b want 0", u, mem_we); end
            tick;
            tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL lb_wait_req[%0d]: got %b want 0", u, mem_req); end
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0000_8000;
            tick;
            mem_rvalid = 1'b0;
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL lb_rsp_valid[%0d]: got %b want 1", u, rsp_valid); end
            tests++; if (rsp_rdata !== exp_data[u]) begin fails++; $display("FAIL lb_rdata[%0d]: got %h want %h", u, rsp_rdata, exp_data[u]); end
            tests++; if (rsp_rd !== 5'd7) begin fails++; $display("FAIL lb_rd[%0d]: got %0d want 7", u, rsp_rd); end
            tick;
        end
    endtask

    task automatic test_load_half_stall;
        drive_req(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 5'd9);
        mem_gnt = 1'b0;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL lh_stall_req[%0d]: got %b want 1", i, mem_req); end
            tests++; if (mem_addr !== 32'h0000_2000) begin fails++; $display("FAIL lh_stall_addr[%0d]: got %h want 00002000", i, mem_addr); end
            tests++; if (mem_be !== 4'b1100) begin fails++; $display("FAIL lh_stall_be[%0d]: got %b want 1100", i, mem_be); end
            tick;
        end
        mem_gnt = 1'b1;
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL lh_gnt_req: got %b want 1", mem_req); end
        tick;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL lh_wait_req: got %b want 0", mem_req); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL lh_early_rsp: got %b want 0", rsp_valid); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_0000;
        tick;
        mem_rvalid = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL lh_rsp_valid: got %b want 1", rsp_valid); end
        tests++; if (rsp_rdata !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_rdata: got %h want ffff8001", rsp_rdata); end
        tests++; if (rsp_rd !== 5'd9) begin fails++; $display("FAIL lh_rd: got %0d want 9", rsp_rd); end
        tick;
    endtask

    task automatic test_store_lanes;
        logic [31:0] a   [2];
        logic [1:0]  sz  [2];
        logic [31:0] d   [2];
        logic [3:0]  ebe [2];
        logic [31:0] ewd [2];
        a[0] = 32'h0000_4002; sz[0] = 2'b01; d[0] = 32'h1234_5678; ebe[0] = 4'b1100; ewd[0] = 32'h5678_5678;
        a[1] = 32'h0000_4000; sz[1] = 2'b10; d[1] = 32'hDEAD_BEEF; ebe[1] = 4'b1111; ewd[1] = 32'hDEAD_BEEF;
        mem_gnt = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive_req(1'b1, sz[k], 1'b0, a[k], d[k], 5'd1);
            tick;
            req_valid = 1'b0;
            tests++; if (mem_be !== ebe[k]) begin fails++; $display("FAIL st_be[%0d]: got %b want %b", k, mem_be, ebe[k]); end
            tests++; if (mem_wdata !== ewd[k]) begin fails++; $display("FAIL st_wdata[%0d]: got %h want %h", k, mem_wdata, ewd[k]); end
            tests++; if (mem_addr !== 32'h0000_4000) begin fails++; $display("FAIL st_addr[%0d]: got %h want 00004000", k, mem_addr); end
            tick;
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL st_rsp[%0d]: got %b want 1", k, rsp_valid); end
            tick;
        end
    endtask

    task automatic test_timeout;
        int n;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 5'd4);
        mem_gnt = 1'b1;
        tick;
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        tests++; if (n !== 8) begin fails++; $display("FAIL to_latency: got %0d cycles want 8", n); end
        tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", rsp_err); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL to_rdata: got %h want 0", rsp_rdata); end
        tests++; if (rsp_rd !== 5'd4) begin fails++; $display("FAIL to_rd: got %0d want 4", rsp_rd); end
        tick;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL to_ready: got %b want 1", req_ready); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        tick;
        mem_rvalid = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL to_idle_rvalid: got %b want 0", rsp_valid); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL to_err_clear: got %b want 0", rsp_err); end
    endtask

    task automatic test_misalign;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0, 5'd11);
        mem_gnt = 1'b1;
        tick;
        req_valid = 1'b0;
`ifdef KAMUS_LSU_MISALIGN_EXC_EN
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mis_mem_req: got %b want 0", mem_req); end
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mis_rsp_valid: got %b want 1", rsp_valid); end
        tests++; if (rsp_err !== 1'b1) begin fails++; $display("FAIL mis_err: got %b want 1", rsp_err); end
        tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL mis_rdata: got %h want 0", rsp_rdata); end
        tick;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mis_ready: got %b want 1", req_ready); end
`else
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL mis_mem_req: got %b want 1", mem_req); end
        tests++; if (mem_addr !== 32'h0000_3000) begin fails++; $display("FAIL mis_addr: got %h want 00003000", mem_addr); end
        tests++; if (mem_be !== 4'b1111) begin fails++; $display("FAIL mis_be: got %b want 1111", mem_be); end
        tick;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_BABE;
        tick;
        mem_rvalid = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mis_rsp_valid: got %b want 1", rsp_valid); end
        tests++; if (rsp_rdata !== 32'hCAFE_BABE) begin fails++; $display("FAIL mis_rdata: got %h want cafebabe", rsp_rdata); end
        tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL mis_err: got %b want 0", rsp_err); end
        tick;
`endif
    endtask

    task automatic test_reset_mid;
        logic seen;
        drive_req(1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0, 5'd2);
        mem_gnt = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        tests++; if (mem_req !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL rm_in_wait: got req=%b ready=%b want 0 0", mem_req, req_ready); end
        rst_ni = 1'b0;
        tick;
        rst_ni = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_00FF;
        tick;
        mem_rvalid = 1'b0;
        seen = rsp_valid;
        for (int i = 0; i < 3; i++) begin
            tick;
            seen = seen | rsp_valid;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rm_no_rsp: got %b want 0", seen); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rm_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back;
        mem_gnt = 1'b1;
        drive_req(1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'h0000_0001, 5'd5);
        tick;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_req: got %b want 0", req_ready); end
        tests++; if (mem_addr !== 32'h0000_5000) begin fails++; $display("FAIL b2b_addr0: got %h want 00005000", mem_addr); end
        req_addr  = 32'h0000_5004;
        req_wdata = 32'h0000_0002;
        req_rd    = 5'd6;
        tick;
        tests++; if (rsp_valid !== 1'b1 || rsp_rd !== 5'd5) begin fails++; $display("FAIL b2b_rsp0: got v=%b rd=%0d want 1 5", rsp_valid, rsp_rd); end
        tick;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_idle: got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5004) begin fails++; $display("FAIL b2b_req1: got req=%b addr=%h want 1 00005004", mem_req, mem_addr); end
        tests++; if (mem_wdata !== 32'h0000_0002) begin fails++; $display("FAIL b2b_wdata1: got %h want 00000002", mem_wdata); end
        tick;
        tests++; if (rsp_valid !== 1'b1 || rsp_rd !== 5'd6) begin fails++; $display("FAIL b2b_rsp1: got v=%b rd=%0d want 1 6", rsp_valid, rsp_rd); end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_rd       = 5'd0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h0;
        test_reset;
        test_store_byte;
        test_load_byte;
        test_load_half_stall;
        test_store_lanes;
        test_timeout;
        test_misalign;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
